// File: rtl/secded_pkg.sv
// Shared types and elaboration-time helpers for the SECDED decoder.
// Codeword positions are 1-based; Hamming bit k lives at position 2^k.
package secded_pkg;

  typedef enum logic [1:0] {
    CLEAN,
    SINGLE_DATA,
    SINGLE_CHECK,
    DOUBLE
  } secded_class_e;

  function automatic logic is_pow2(input int x);
    return (x > 0) && ((x & (x - 1)) == 0);
  endfunction

  // Data bits take the non-power-of-two positions in ascending order.
  function automatic int data_pos(input int i);
    int pos;
    pos = 2;
    for (int n = 0; n <= i; n++) begin
      pos++;
      if (is_pow2(pos)) pos++;
    end
    return pos;
  endfunction

  function automatic int min_par_w(input int data_w);
    int p;
    p = 31;
    for (int q = 30; q >= 1; q--) begin
      if ((1 << q) >= data_w + q + 1) p = q;
    end
    return p;
  endfunction

endpackage

// File: rtl/secded_syndrome.sv
// Combinational syndrome and overall-parity generation for one received word.
module secded_syndrome
  import secded_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PAR_W  = 6
) (
  input  logic [DATA_W-1:0] i_data,
  input  logic [PAR_W:0]    i_check,
  output logic [PAR_W-1:0]  o_syndrome,
  output logic              o_pall
);

  logic [PAR_W-1:0][DATA_W-1:0] w_mask;

  for (genvar k = 0; k < PAR_W; k++) begin : g_syn
    for (genvar i = 0; i < DATA_W; i++) begin : g_bit
      localparam int POS = data_pos(i);
      assign w_mask[k][i] = POS[k];
    end
    assign o_syndrome[k] = i_check[k] ^ (^(i_data & w_mask[k]));
  end

  assign o_pall = (^i_data) ^ (^i_check);

endmodule

// File: rtl/secded_decoder_pipe.sv
// Two-stage valid/ready SECDED decoder with saturating error counters.
// Define SECDED_ERR_LOG_EN to add a sticky log of the first uncorrectable word.
module secded_decoder_pipe
  import secded_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PAR_W  = 6,
  parameter int TAG_W  = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [PAR_W:0]    in_check,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [PAR_W:0]    out_check,
  output logic [TAG_W-1:0]  out_tag,
  output logic [PAR_W-1:0]  out_syndrome,
  output logic              out_single,
  output logic              out_double,
  input  logic              cnt_clr,
`ifdef SECDED_ERR_LOG_EN
  output logic              log_valid,
  output logic [TAG_W-1:0]  log_tag,
  output logic [PAR_W-1:0]  log_syndrome,
`endif
  output logic [CNT_W-1:0]  single_cnt,
  output logic [CNT_W-1:0]  double_cnt
);

  localparam int N = DATA_W + PAR_W;
  localparam logic [PAR_W-1:0] LAST_POS = PAR_W'(N);

  if (PAR_W < min_par_w(DATA_W)) begin : g_par_check
    $error("secded_decoder_pipe: PAR_W too small for DATA_W");
  end

  logic w_s1_ready, w_s2_ready, w_out_fire;

  logic                r_v1;
  logic [DATA_W-1:0]   r_data1;
  logic [PAR_W:0]      r_check1;
  logic [TAG_W-1:0]    r_tag1;
  logic [PAR_W-1:0]    r_syn1;
  logic                r_pall1;

  logic                r_v2;
  logic [DATA_W-1:0]   r_data2;
  logic [PAR_W:0]      r_check2;
  logic [TAG_W-1:0]    r_tag2;
  logic [PAR_W-1:0]    r_syn2;
  logic                r_single2, r_double2;

  logic [CNT_W-1:0]    r_single_cnt, r_double_cnt;

  logic [PAR_W-1:0]    w_syn;
  logic                w_pall;

  assign w_s2_ready = !r_v2 || out_ready;
  assign w_s1_ready = !r_v1 || w_s2_ready;
  assign w_out_fire = r_v2 && out_ready;
  assign in_ready   = w_s1_ready;

  secded_syndrome #(
    .DATA_W (DATA_W),
    .PAR_W  (PAR_W)
  ) u_syndrome (
    .i_data     (in_data),
    .i_check    (in_check),
    .o_syndrome (w_syn),
    .o_pall     (w_pall)
  );

  // NOTE: payload registers are reset along with the valids so every output reads 0 after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1     <= 1'b0;
      r_data1  <= '0;
      r_check1 <= '0;
      r_tag1   <= '0;
      r_syn1   <= '0;
      r_pall1  <= 1'b0;
    end else if (w_s1_ready) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      r_v1 <= in_valid;
      if (in_valid) begin
        r_data1  <= in_data;
        r_check1 <= in_check;
        r_tag1   <= in_tag;
        r_syn1   <= w_syn;
        r_pall1  <= w_pall;
      end
    end
  end

  logic [DATA_W-1:0] w_data_hit;
  logic [PAR_W-1:0]  w_chk_hit;

  for (genvar i = 0; i < DATA_W; i++) begin : g_data_hit
    localparam int POS = data_pos(i);
    assign w_data_hit[i] = (r_syn1 == PAR_W'(POS));
  end

  for (genvar k = 0; k < PAR_W; k++) begin : g_chk_hit
    assign w_chk_hit[k] = (r_syn1 == PAR_W'(1 << k));
  end

  secded_class_e     w_class;
  logic [DATA_W-1:0] w_data_fix;
  logic [PAR_W:0]    w_check_fix;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_class     = CLEAN;
    w_data_fix  = r_data1;
    w_check_fix = r_check1;
    if (r_pall1) begin
      if (r_syn1 == '0) begin
        w_class            = SINGLE_CHECK;
        w_check_fix[PAR_W] = ~r_check1[PAR_W];
      end else if (r_syn1 > LAST_POS) begin
        w_class = DOUBLE;
      end else if (|w_chk_hit) begin
        w_class     = SINGLE_CHECK;
        w_check_fix = r_check1 ^ {1'b0, w_chk_hit};
      end else begin
        w_class    = SINGLE_DATA;
        w_data_fix = r_data1 ^ w_data_hit;
      end
    end else if (r_syn1 != '0) begin
      w_class = DOUBLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v2      <= 1'b0;
      r_data2   <= '0;
      r_check2  <= '0;
      r_tag2    <= '0;
      r_syn2    <= '0;
      r_single2 <= 1'b0;
      r_double2 <= 1'b0;
    end else if (w_s2_ready) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_data2   <= w_data_fix;
        r_check2  <= w_check_fix;
        r_tag2    <= r_tag1;
        r_syn2    <= r_syn1;
        r_single2 <= (w_class == SINGLE_DATA) || (w_class == SINGLE_CHECK);
        r_double2 <= (w_class == DOUBLE);
      end
    end
  end

  // Clear wins over a same-cycle increment; counts stick at all ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_single_cnt <= '0;
      r_double_cnt <= '0;
    end else if (cnt_clr) begin
      r_single_cnt <= '0;
      r_double_cnt <= '0;
    end else if (w_out_fire) begin
      if (r_single2 && (r_single_cnt != '1)) r_single_cnt <= r_single_cnt + 1'b1;
      if (r_double2 && (r_double_cnt != '1)) r_double_cnt <= r_double_cnt + 1'b1;
    end
  end

`ifdef SECDED_ERR_LOG_EN
  logic               r_log_valid;
  logic [TAG_W-1:0]   r_log_tag;
  logic [PAR_W-1:0]   r_log_syn;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_log_valid <= 1'b0;
      r_log_tag   <= '0;
      r_log_syn   <= '0;
    end else if (cnt_clr) begin
      r_log_valid <= 1'b0;
      r_log_tag   <= '0;
      r_log_syn   <= '0;
    end else if (w_out_fire && r_double2 && !r_log_valid) begin
      r_log_valid <= 1'b1;
      r_log_tag   <= r_tag2;
      r_log_syn   <= r_syn2;
    end
  end

  assign log_valid    = r_log_valid;
  assign log_tag      = r_log_tag;
  assign log_syndrome = r_log_syn;
`endif

  assign out_valid    = r_v2;
  assign out_data     = r_data2;
  assign out_check    = r_check2;
  assign out_tag      = r_tag2;
  assign out_syndrome = r_syn2;
  assign out_single   = r_single2;
  assign out_double   = r_double2;
  assign single_cnt   = r_single_cnt;
  assign double_cnt   = r_double_cnt;

endmodule

// File: tb/tb_secded_decoder_pipe.sv
// Directed bench for secded_decoder_pipe: vector table, backpressure, counters, reset.
module tb_secded_decoder_pipe;

  localparam int DATA_W  = 32;
  localparam int PAR_W   = 6;
  localparam int TAG_W   = 8;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int NV      = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid, in_ready, out_valid, out_ready, cnt_clr;
  logic [DATA_W-1:0] in_data, out_data;
  logic [PAR_W:0]    in_check, out_check;
  logic [TAG_W-1:0]  in_tag, out_tag;
  logic [PAR_W-1:0]  out_syndrome;
  logic              out_single, out_double;
  logic [CNT_W-1:0]  single_cnt, double_cnt;
`ifdef SECDED_ERR_LOG_EN
  logic              log_valid;
  logic [TAG_W-1:0]  log_tag;
  logic [PAR_W-1:0]  log_syndrome;
`endif

  always #5 clk = ~clk;

  secded_decoder_pipe #(
    .DATA_W (DATA_W),
    .PAR_W  (PAR_W),
    .TAG_W  (TAG_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_check     (in_check),
    .in_tag       (in_tag),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_check    (out_check),
    .out_tag      (out_tag),
    .out_syndrome (out_syndrome),
    .out_single   (out_single),
    .out_double   (out_double),
    .cnt_clr      (cnt_clr),
`ifdef SECDED_ERR_LOG_EN
    .log_valid    (log_valid),
    .log_tag      (log_tag),
    .log_syndrome (log_syndrome),
`endif
    .single_cnt   (single_cnt),
    .double_cnt   (double_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference encoder walking codeword positions 1..N.
  function automatic logic [PAR_W:0] enc(input logic [DATA_W-1:0] d);
    logic [PAR_W:0] c;
    int di;
    c  = '0;
    di = 0;
    for (int p = 1; p <= DATA_W + PAR_W; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (d[di]) begin
          for (int k = 0; k < PAR_W; k++) if (p[k]) c[k] = ~c[k];
        end
        di++;
      end
    end
    c[PAR_W] = (^d) ^ (^c[PAR_W-1:0]);
    return c;
  endfunction

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] dflip;
    logic [PAR_W:0]    cflip;
    logic [PAR_W-1:0]  syn;
    logic              single;
    logic              dbl;
  } vec_t;

  vec_t vecs [NV];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [PAR_W:0]    clean_c;
    logic [DATA_W-1:0] exp_data;
    logic [PAR_W:0]    exp_check;
    int lat, exp_sc, exp_dc, wait_n;
    int acc, got, cyc, first_block;
    logic held;
    logic [DATA_W-1:0] h_data;
    logic [TAG_W-1:0]  h_tag;
    logic [DATA_W-1:0] got_data [$];
    logic [TAG_W-1:0]  got_tag  [$];

    vecs[0] = '{32'hDEADBEEF, 32'h0000_0000, 7'h00, 6'd0,  1'b0, 1'b0};
    vecs[1] = '{32'hDEADBEEF, 32'h0000_0001, 7'h00, 6'd3,  1'b1, 1'b0};
    vecs[2] = '{32'hDEADBEEF, 32'h0000_0000, 7'h04, 6'd4,  1'b1, 1'b0};
    vecs[3] = '{32'hDEADBEEF, 32'h0000_0000, 7'h40, 6'd0,  1'b1, 1'b0};
    vecs[4] = '{32'hDEADBEEF, 32'h0000_0003, 7'h00, 6'd6,  1'b0, 1'b1};
    vecs[5] = '{32'h00000000, 32'h0000_0000, 7'h00, 6'd0,  1'b0, 1'b0};
    vecs[6] = '{32'hFFFFFFFF, 32'h8000_0000, 7'h00, 6'd38, 1'b1, 1'b0};
    vecs[7] = '{32'h12345678, 32'h0000_0010, 7'h01, 6'd8,  1'b0, 1'b1};
    vecs[8] = '{32'h12345678, 32'h0400_0003, 7'h00, 6'd39, 1'b0, 1'b1};
    vecs[9] = '{32'h12345678, 32'h0000_0004, 7'h00, 6'd6,  1'b1, 1'b0};

    in_valid  = 1'b0;
    in_data   = '0;
    in_check  = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    cnt_clr   = 1'b0;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_data", out_data, 0);
    check("rst_flags", {out_single, out_double}, 0);
    check("rst_counts", {single_cnt, double_cnt}, 0);
    step();
    rst = 1'b0;

    exp_sc = 0;
    exp_dc = 0;
    for (int v = 0; v < NV; v++) begin
      clean_c   = enc(vecs[v].data);
      in_data   = vecs[v].data ^ vecs[v].dflip;
      in_check  = clean_c ^ vecs[v].cflip;
      in_tag    = TAG_W'(v + 1);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      exp_data  = vecs[v].dbl ? in_data : vecs[v].data;
      exp_check = vecs[v].dbl ? in_check : clean_c;
      #1;
      check($sformatf("v%0d_in_ready", v), in_ready, 1);
      step();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 8) begin
        step();
        lat++;
      end
      check($sformatf("v%0d_latency", v), lat, 2);
      check($sformatf("v%0d_data", v), out_data, exp_data);
      check($sformatf("v%0d_check", v), out_check, exp_check);
      check($sformatf("v%0d_tag", v), out_tag, v + 1);
      check($sformatf("v%0d_syndrome", v), out_syndrome, vecs[v].syn);
      check($sformatf("v%0d_single", v), out_single, vecs[v].single);
      check($sformatf("v%0d_double", v), out_double, vecs[v].dbl);
      step();
      if (vecs[v].single && exp_sc < CNT_MAX) exp_sc++;
      if (vecs[v].dbl && exp_dc < CNT_MAX) exp_dc++;
      check($sformatf("v%0d_single_cnt", v), single_cnt, exp_sc);
      check($sformatf("v%0d_double_cnt", v), double_cnt, exp_dc);
      check($sformatf("v%0d_drained", v), out_valid, 0);
    end

`ifdef SECDED_ERR_LOG_EN
    check("log_valid", log_valid, 1);
    check("log_tag", log_tag, 8'h05);
    check("log_syndrome", log_syndrome, 6'd6);
`endif

    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    check("clr_counts", {single_cnt, double_cnt}, 0);
`ifdef SECDED_ERR_LOG_EN
    check("clr_log_valid", log_valid, 0);
`endif

    // Saturation: four back-to-back single errors on a 2-bit counter.
    for (int i = 0; i < 4; i++) begin
      in_data  = (32'hCAFE_0000 + 32'(i)) ^ 32'h0000_0004;
      in_check = enc(32'hCAFE_0000 + 32'(i));
      in_tag   = TAG_W'(8'h30 + i);
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("sat_single_cnt", single_cnt, 3);
    check("sat_double_cnt", double_cnt, 0);

    // Clear on the same edge as a single-error output handshake.
    cnt_clr = 1'b1;
    step();
    cnt_clr  = 1'b0;
    in_data  = 32'h0BAD_F00D ^ 32'h0000_0001;
    in_check = enc(32'h0BAD_F00D);
    in_tag   = 8'h44;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_n = 0;
    while (!out_valid && wait_n < 8) begin
      step();
      wait_n++;
    end
    check("clrhs_out_valid", out_valid, 1);
    check("clrhs_single", out_single, 1);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    check("clrhs_single_cnt", single_cnt, 0);

    // Backpressure: five words, consumer stalled for the first three cycles.
    acc = 0;
    got = 0;
    cyc = 0;
    first_block = -1;
    held = 1'b0;
    h_data = '0;
    h_tag  = '0;
    while (got < 5 && cyc < 40) begin
      out_ready = (cyc >= 3);
      in_valid  = (acc < 5);
      in_data   = 32'h1000_0000 + 32'(acc);
      in_check  = enc(32'h1000_0000 + 32'(acc));
      in_tag    = TAG_W'(8'hA0 + acc);
      #1;
      if (held) begin
        check("bp_stall_data", out_data, h_data);
        check("bp_stall_tag", out_tag, h_tag);
      end
      held   = out_valid && !out_ready;
      h_data = out_data;
      h_tag  = out_tag;
      if (!in_ready && first_block < 0) first_block = acc;
      if (out_valid && out_ready) begin
        got_data.push_back(out_data);
        got_tag.push_back(out_tag);
        got++;
      end
      if (in_valid && in_ready) acc++;
      step();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp_block_after", first_block, 2);
    check("bp_word_count", got, 5);
    for (int i = 0; i < got; i++) begin
      check($sformatf("bp_tag%0d", i), got_tag[i], 8'hA0 + i);
      check($sformatf("bp_data%0d", i), got_data[i], 32'h1000_0000 + i);
    end
    step();
    check("bp_no_extra", out_valid, 0);

    // Reset in the middle of a stalled stream of single-error words.
    cnt_clr = 1'b1;
    step();
    cnt_clr   = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_data  = (32'h5555_0000 + 32'(i)) ^ 32'h0000_0002;
      in_check = enc(32'h5555_0000 + 32'(i));
      in_tag   = TAG_W'(8'h60 + i);
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    check("mid_full", out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_single", out_single, 0);
    step();
    rst       = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("post_rst_idle%0d", i), out_valid, 0);
    end
    check("post_rst_single_cnt", single_cnt, 0);
`ifdef SECDED_ERR_LOG_EN
    check("post_rst_log_valid", log_valid, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
